booth4_mult_ctrl: RTL and testbench

- Multicycle signed multiplier for the processor's multdiv unit, using radix-4 (modified) Booth recoding.
- Sequences a product/multiplier register through WIDTH/2 add-then-arithmetic-shift-right-by-2 iterations.
- Issues a one-cycle ready pulse with the low word of the product and an overflow exception.
- Sits between the pipeline's X stage (start pulse, operands) and its stall/writeback logic (busy, ready).

---
 rtl/mult_pkg.sv | 34 +++
 rtl/booth4_mult_ctrl_if.sv | 28 ++
 rtl/booth4_pp_sel.sv | 29 ++
 rtl/booth4_mult_ctrl.sv | 111 +++++++++++
 tb/tb_booth4_mult_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the radix-4 Booth multiplier
// Contents: default width and iteration count, controller state enum,
//           Booth select encoding and the 3-bit recoding helper.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = MULT_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } multState_e;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM,
        SEL_P2M,
        SEL_NM,
        SEL_N2M
    } boothSel_e;

    // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}
    function automatic boothSel_e boothDecode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: boothDecode = SEL_PM;
            3'b011:         boothDecode = SEL_P2M;
            3'b100:         boothDecode = SEL_N2M;
            3'b101, 3'b110: boothDecode = SEL_NM;
            default:        boothDecode = SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth4_mult_ctrl_if.sv
// rtl/booth4_mult_ctrl_if.sv - X-stage / writeback handshake bundle for the multiplier
// Signals: ctrl_MULT (start), data_operandA/B (operands), data_result,
//          data_exception, data_resultRDY (completion pulse), busy.
// Modports: master = pipeline side, slave = multiplier side.
interface booth4_mult_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/booth4_pp_sel.sv
// rtl/booth4_pp_sel.sv - radix-4 Booth partial-product addend selector
// Ports: boothBits (P[2:0]), multiplicand (sign-extended M, WIDTH+2),
//        addend (0, +M, +2M, -M or -2M, WIDTH+2, modulo 2^(WIDTH+2)).
module booth4_pp_sel
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2:0]       boothBits,
    input  logic [WIDTH+1:0] multiplicand,
    output logic [WIDTH+1:0] addend
);

    boothSel_e sel;

    // Two guard bits on M keep +/-2M of the most negative operand in range.
    always_comb begin
        sel    = boothDecode(boothBits);
        addend = '0;
        case (sel)
            SEL_PM:  addend = multiplicand;
            SEL_P2M: addend = multiplicand << 1;
            SEL_NM:  addend = -multiplicand;
            SEL_N2M: addend = -(multiplicand << 1);
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth4_mult_ctrl.sv
// rtl/booth4_mult_ctrl.sv - multicycle radix-4 Booth signed multiplier controller
// Ports: clock, reset (async active-low), bus (booth4_mult_ctrl_if.slave).
// Runs WIDTH/2 add-then-shift-by-2 iterations, then pulses data_resultRDY
// for one cycle with the low product word and an overflow flag.
// Optional: BOOTH4_ZERO_BYPASS_EN - zero operand finishes in one cycle.
module booth4_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    booth4_mult_ctrl_if.slave bus
);

    localparam int ITERS = WIDTH / 2;
    localparam int PW    = 2 * WIDTH + 3;
    localparam int CW    = $clog2(ITERS + 1);

    multState_e         state;
    multState_e         nextState;
    logic [WIDTH+1:0]   multReg;
    logic [PW-1:0]      prodReg;
    logic [PW-1:0]      prodShifted;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   accSum;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      iterCount;
    logic [WIDTH-1:0]   resultReg;
    logic               exceptReg;
    logic               lastIter;
    logic               zeroOp;
    logic               overflow;

    booth4_pp_sel #(.WIDTH(WIDTH)) ppSel (
        .boothBits    (prodReg[2:0]),
        .multiplicand (multReg),
        .addend       (addend)
    );

`ifdef BOOTH4_ZERO_BYPASS_EN
    assign zeroOp = (bus.data_operandA == '0) || (bus.data_operandB == '0);
`else
    assign zeroOp = 1'b0;
`endif

    // prodReg = {acc[WIDTH+1:0], multiplier[WIDTH-1:0], q-1}
    assign accSum      = prodReg[PW-1:WIDTH+1] + addend;
    assign prodShifted = {{2{accSum[WIDTH+1]}}, accSum, prodReg[WIDTH:2]};
    assign product     = prodShifted[2*WIDTH:1];
    assign lastIter    = (iterCount == CW'(ITERS - 1));
    // Representable iff the upper half is a pure sign extension of bit WIDTH-1.
    assign overflow    = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.ctrl_MULT) nextState = zeroOp ? DONE : RUN;
            RUN:     if (lastIter) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            multReg   <= '0;
            prodReg   <= '0;
            iterCount <= '0;
            resultReg <= '0;
            exceptReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ctrl_MULT) begin
                        multReg   <= {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                        prodReg   <= {{(WIDTH + 2){1'b0}}, bus.data_operandB, 1'b0};
                        iterCount <= '0;
                        if (zeroOp) begin
                            resultReg <= '0;
                            exceptReg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    prodReg   <= prodShifted;
                    iterCount <= iterCount + CW'(1);
                    if (lastIter) begin
                        resultReg <= product[WIDTH-1:0];
                        exceptReg <= overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = resultReg;
    assign bus.data_exception = exceptReg;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state == RUN);

endmodule

// File: tb/tb_booth4_mult_ctrl.sv
// tb/tb_booth4_mult_ctrl.sv - self-checking bench for booth4_mult_ctrl
module tb_booth4_mult_ctrl;

`ifdef BOOTH4_ZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif
    localparam int FULL_LAT = 17;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   edgeCnt = 0;
    int   busyCnt = 0;

    always #5 clock = ~clock;

    booth4_mult_ctrl_if #(.WIDTH(32)) bus ();

    booth4_mult_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plain 64-bit signed arithmetic reference.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic exc);
        longint p;
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p[31:0];
        exc = (p > longint'(32'h7FFF_FFFF)) || (p < -longint'(32'h8000_0000));
    endtask

    function automatic int latFor(input logic [31:0] a, input logic [31:0] b);
        return (BYPASS_EN && (a == 0 || b == 0)) ? 1 : FULL_LAT;
    endfunction

    task automatic tick();
        if (bus.busy) busyCnt++;
        @(negedge clock);
        edgeCnt++;
    endtask

    // Called at a negedge; the following posedge is E0.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        edgeCnt = 0;
        busyCnt = 0;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic waitDone(input string tag, input logic [31:0] expRes,
                            input logic expExc, input int expLat);
        while (!bus.data_resultRDY && edgeCnt < 200) tick();
        check({tag, " rdy"}, 32'(bus.data_resultRDY), 32'd1);
        check({tag, " latency"}, 32'(edgeCnt), 32'(expLat));
        check({tag, " busyCycles"}, 32'(busyCnt), 32'(expLat - 1));
        check({tag, " result"}, bus.data_result, expRes);
        check({tag, " exception"}, 32'(bus.data_exception), 32'(expExc));
        check({tag, " busyAtRdy"}, 32'(bus.busy), 32'd0);
        @(negedge clock);
        check({tag, " rdyOneCycle"}, 32'(bus.data_resultRDY), 32'd0);
    endtask

    task automatic runExp(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes, input logic expExc);
        startOp(a, b);
        waitDone(tag, expRes, expExc, latFor(a, b));
    endtask

    task automatic runRef(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ee;
        refModel(a, b, er, ee);
        runExp(tag, a, b, er, ee);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h0000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int rdyPulses;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        repeat (3) @(negedge clock);
        check("resetResult", bus.data_result, 32'd0);
        check("resetException", 32'(bus.data_exception), 32'd0);
        check("resetRdy", 32'(bus.data_resultRDY), 32'd0);
        check("resetBusy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idleBusy", 32'(bus.busy), 32'd0);

        runExp("basic", 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0);
        runExp("ovfMaxX2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        runExp("ovfMinXm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runExp("minX1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

        // Second start pulse while running must be dropped.
        startOp(32'd5, 32'd6);
        repeat (4) tick();
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        tick();
        bus.ctrl_MULT = 1'b0;
        waitDone("busyIgnore", 32'd30, 1'b0, FULL_LAT);
        rdyPulses = 0;
        repeat (30) begin
            if (bus.data_resultRDY) rdyPulses++;
            @(negedge clock);
        end
        check("busyIgnoreNoSecond", 32'(rdyPulses), 32'd0);
        check("busyIgnoreIdle", 32'(bus.busy), 32'd0);

        // Abort after iteration 8.
        startOp(32'd1234, 32'd5678);
        while (edgeCnt < 9) tick();
        reset = 1'b0;
        #1;
        check("abortBusy", 32'(bus.busy), 32'd0);
        check("abortResult", bus.data_result, 32'd0);
        check("abortRdy", 32'(bus.data_resultRDY), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rdyPulses = 0;
        repeat (30) begin
            if (bus.data_resultRDY) rdyPulses++;
            @(negedge clock);
        end
        check("abortNoRdy", 32'(rdyPulses), 32'd0);
        runExp("afterAbort", 32'd100, -32'sd100, 32'hFFFF_D8F0, 1'b0);

        runExp("b2bFirst", 32'd3, 32'd4, 32'd12, 1'b0);
        runExp("b2bSecond", 32'd12, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

        runExp("zeroA", 32'd0, 32'h1234_5678, 32'd0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            runRef($sformatf("rand%0d", i), pickOperand(), pickOperand());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
